audio_status_in_pio: RTL and testbench



---
 rtl/audio_pio_pkg.sv | 13 +
 rtl/pio_sync_edge.sv | 44 ++++
 rtl/audio_status_in_pio.sv | 106 ++++++++++
 tb/tb_audio_status_in_pio.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pio_pkg.sv
// Shared definitions for the audio PIO ports: register offsets and capture-edge encodings.
package audio_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Synchronizer chain for asynchronous PIO inputs plus a one-cycle history
// register and the selected edge-detect vector.
module pio_sync_edge
    import audio_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_s,
    output logic [WIDTH-1:0] edge_s
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_r;
    logic [WIDTH-1:0]                  prev_r;

    assign sync_s = chain_r[SYNC_STAGES-1];

    // Shift the raw inputs through the synchronizer and keep last cycle's value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_r <= '0;
            prev_r  <= '0;
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], in_port};
            prev_r  <= chain_r[SYNC_STAGES-1];
        end
    end

    // Edge vector for the configured capture polarity.
    always_comb begin
        edge_s = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_s = sync_s & ~prev_r;
            EDGE_FALL: edge_s = ~sync_s & prev_r;
            EDGE_ANY:  edge_s = sync_s ^ prev_r;
            default:   edge_s = sync_s & ~prev_r;
        endcase
    end

endmodule

// File: rtl/audio_status_in_pio.sv
// Avalon-MM input PIO for audio status lines with sticky edge capture and a
// maskable level interrupt. Build option: AUDIO_STATUS_PIO_BIT_CLEAR_EN selects
// write-1-to-clear on EDGE_CAPTURE instead of clear-all on any write.
module audio_status_in_pio
    import audio_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] irq_mask_r;
    logic [WIDTH-1:0] edge_capture_r;
    logic [WIDTH-1:0] mask_nxt_s;
    logic [WIDTH-1:0] cap_nxt_s;
    logic [WIDTH-1:0] clr_s;
    logic [31:0]      rd_mux_s;
    logic [31:0]      readdata_r;
    logic             irq_r;
    logic             wr_s;
    logic             rd_s;
    logic [31:0]      wdata_unused_s;

    assign wdata_unused_s = writedata;
    assign wr_s     = chipselect && !write_n;
    assign rd_s     = chipselect && !read_n;
    assign readdata = readdata_r;
    assign irq      = irq_r;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .sync_s  (sync_s),
        .edge_s  (edge_s)
    );

    // Next mask and capture state; a new edge wins over a clear of the same bit.
    always_comb begin
        mask_nxt_s = irq_mask_r;
        clr_s      = '0;
        if (wr_s && (address == ADDR_MASK)) begin
            mask_nxt_s = writedata[WIDTH-1:0];
        end else begin
            mask_nxt_s = irq_mask_r;
        end
        if (wr_s && (address == ADDR_EDGE)) begin
`ifdef AUDIO_STATUS_PIO_BIT_CLEAR_EN
            clr_s = writedata[WIDTH-1:0];
`else
            clr_s = '1;
`endif
        end else begin
            clr_s = '0;
        end
        cap_nxt_s = (edge_capture_r & ~clr_s) | edge_s;
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (address)
            ADDR_DATA: rd_mux_s[WIDTH-1:0] = sync_s;
            ADDR_MASK: rd_mux_s[WIDTH-1:0] = irq_mask_r;
            ADDR_EDGE: rd_mux_s[WIDTH-1:0] = edge_capture_r;
            default:   rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Register file, read data and interrupt; irq tracks the registered mask/capture pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_r     <= '0;
            edge_capture_r <= '0;
            readdata_r     <= 32'h0000_0000;
            irq_r          <= 1'b0;
        end else begin
            irq_mask_r     <= mask_nxt_s;
            edge_capture_r <= cap_nxt_s;
            irq_r          <= |(cap_nxt_s & mask_nxt_s);
            if (rd_s) begin
                readdata_r <= rd_mux_s;
            end else begin
                readdata_r <= readdata_r;
            end
        end
    end

endmodule

// File: tb/tb_audio_status_in_pio.sv
// Randomized bench for audio_status_in_pio against a cycle-level reference model
// built from the sampled-input history.
module tb_audio_status_in_pio;

    localparam int W    = 8;
    localparam int ET   = 0;
    localparam int SYNC = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   address = 2'd0;
    logic         chipselect = 1'b0;
    logic         read_n = 1'b1;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = 32'h0;
    logic [W-1:0] in_port = '0;
    logic [31:0]  readdata;
    logic         irq;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [W-1:0] m_samp[$];
    logic [W-1:0] m_mask;
    logic [W-1:0] m_cap;
    logic [31:0]  m_rd;
    logic         m_irq;

    audio_status_in_pio #(.WIDTH(W), .EDGE_TYPE(ET), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] edges_of(input logic [W-1:0] cur, input logic [W-1:0] old);
        logic [W-1:0] r;
        r = '0;
        for (int b = 0; b < W; b++) begin
            if (ET == 0)      r[b] = (cur[b] == 1'b1) && (old[b] == 1'b0);
            else if (ET == 1) r[b] = (cur[b] == 1'b0) && (old[b] == 1'b1);
            else              r[b] = (cur[b] != old[b]);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_samp.delete();
        for (int i = 0; i <= SYNC; i++) m_samp.push_back('0);
        m_mask = '0;
        m_cap  = '0;
        m_rd   = 32'h0;
        m_irq  = 1'b0;
    endtask

    // One bus cycle: drive at negedge, model the posedge, check at the next negedge.
    task automatic step(input logic [W-1:0] inv, input logic rd, input logic wr,
                        input logic [1:0] addr, input logic [31:0] wd);
        logic [W-1:0] s_pre, p_pre, ev, clr;
        in_port    = inv;
        chipselect = rd | wr;
        read_n     = !rd;
        write_n    = !wr;
        address    = addr;
        writedata  = wd;
        @(posedge clk);
        s_pre = m_samp[1];
        p_pre = m_samp[0];
        m_samp.push_back(inv);
        void'(m_samp.pop_front());
        ev = edges_of(s_pre, p_pre);
        if (rd) begin
            if (addr == 2'd0)      m_rd = 32'(s_pre);
            else if (addr == 2'd2) m_rd = 32'(m_mask);
            else if (addr == 2'd3) m_rd = 32'(m_cap);
            else                   m_rd = 32'h0;
        end
        clr = '0;
        if (wr && addr == 2'd3) begin
`ifdef AUDIO_STATUS_PIO_BIT_CLEAR_EN
            clr = wd[W-1:0];
`else
            clr = '1;
`endif
        end
        m_cap = (m_cap & ~clr) | ev;
        if (wr && addr == 2'd2) m_mask = wd[W-1:0];
        m_irq = |(m_cap & m_mask);
        @(negedge clk);
        check_eq("readdata", readdata, m_rd);
        check_eq("irq", {31'h0, irq}, {31'h0, m_irq});
    endtask

    task automatic idle(input logic [W-1:0] inv, input int n);
        for (int i = 0; i < n; i++) step(inv, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    initial begin
        logic [W-1:0] cur;
        logic [31:0]  exp_clr;
        model_reset();
        // reset held with inputs high, released with inputs low
        in_port = 8'hFF;
        repeat (3) @(negedge clk);
        check_eq("reset_rdata", readdata, 32'h0);
        check_eq("reset_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        idle(8'h00, 10);
        step(8'h00, 1'b1, 1'b0, 2'd0, 32'h0);
        step(8'h00, 1'b1, 1'b0, 2'd2, 32'h0);
        step(8'h00, 1'b1, 1'b0, 2'd3, 32'h0);
        check_eq("reset_cap", readdata, 32'h0);

        // data path
        idle(8'hA5, 3);
        step(8'hA5, 1'b1, 1'b0, 2'd0, 32'h0);
        check_eq("data_a5", readdata, 32'h0000_00A5);
        step(8'hA5, 1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF);
        step(8'hA5, 1'b1, 1'b0, 2'd1, 32'h0);
        check_eq("reserved", readdata, 32'h0);

        // rising capture and irq masking
        idle(8'h00, 4);
        step(8'h00, 1'b0, 1'b1, 2'd3, 32'hFF);
        step(8'h00, 1'b0, 1'b1, 2'd2, 32'h01);
        idle(8'h01, 3);
        check_eq("irq_bit0", {31'h0, irq}, (ET == 1) ? 32'h0 : 32'h1);
        step(8'h03, 1'b0, 1'b0, 2'd0, 32'h0);
        idle(8'h01, 3);
        step(8'h01, 1'b0, 1'b1, 2'd2, 32'h00);
        step(8'h01, 1'b1, 1'b0, 2'd3, 32'h0);

        // clear semantics
        idle(8'h00, 4);
        step(8'h00, 1'b0, 1'b1, 2'd3, 32'hFF);
        idle(8'h0F, 4);
        step(8'h0F, 1'b0, 1'b1, 2'd3, 32'h05);
        step(8'h0F, 1'b1, 1'b0, 2'd3, 32'h0);
`ifdef AUDIO_STATUS_PIO_BIT_CLEAR_EN
        exp_clr = 32'h0A;
`else
        exp_clr = 32'h00;
`endif
        if (ET == 0) check_eq("clear_sem", readdata, exp_clr);

        // edge on bit 2 meets a clear of bit 2 in the same cycle
        idle(8'h00, 4);
        step(8'h00, 1'b0, 1'b1, 2'd3, 32'hFF);
        step(8'h04, 1'b0, 1'b0, 2'd0, 32'h0);
        step(8'h04, 1'b0, 1'b0, 2'd0, 32'h0);
        step(8'h04, 1'b0, 1'b1, 2'd3, 32'h04);
        step(8'h04, 1'b1, 1'b0, 2'd3, 32'h0);
        if (ET != 1) check_eq("collision", readdata & 32'h4, 32'h4);

        // randomized traffic with glitches and sporadic register access
        cur = '0;
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] v;
            int op;
            v = cur;
            if ($urandom_range(0, 3) == 0) v = cur ^ W'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                step(cur ^ W'($urandom), 1'b0, 1'b0, 2'd0, 32'h0);
            end
            cur = v;
            op = $urandom_range(0, 9);
            if (op < 5)       step(cur, 1'b1, 1'b0, 2'($urandom_range(0, 3)), 32'h0);
            else if (op < 7)  step(cur, 1'b0, 1'b1, 2'd3, $urandom);
            else if (op == 7) step(cur, 1'b0, 1'b1, 2'd2, $urandom);
            else              step(cur, 1'b0, 1'b0, 2'd0, 32'h0);
        end

        // asynchronous reset mid-operation
        step(cur, 1'b0, 1'b1, 2'd2, 32'hFF);
        step(cur ^ 8'hFF, 1'b1, 1'b0, 2'd3, 32'h0);
        idle(cur ^ 8'hFF, 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("midrst_rdata", readdata, 32'h0);
        check_eq("midrst_irq", {31'h0, irq}, 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cur = ($urandom_range(0, 2) == 0) ? W'($urandom) : cur;
            step(cur, 1'b1, ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
